// File: rtl/huffman_frame_scheduler.sv
`default_nettype none
// ============================================================================
// huffman_frame_scheduler: sequences Huffman decoder reset/prime/advance per
// frame and double-buffers the compressed-image RAM banks.   Rev 1.0
// ============================================================================
module huffman_frame_scheduler #(
  parameter int ADDR_WIDTH       = 16,
  parameter int PIXELS_PER_FRAME = 307200,
  parameter int PIX_CNT_WIDTH    = 20,
  parameter int PRIME_CYCLES     = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_start,
  input  logic                  pixel_valid,
  input  logic                  host_commit,
  input  logic [ADDR_WIDTH-1:0] dec_RAM_address,
  output logic                  dec_pixel_reset,
  output logic                  dec_pixel_read_next,
  output logic [ADDR_WIDTH:0]   ram_address,
  output logic                  host_bank,
  output logic                  pixel_blank,
  output logic [15:0]           frame_count,
  output logic                  pixel_underrun,
  output logic                  frame_overrun
);

  localparam int PRIME_CNT_WIDTH = (PRIME_CYCLES > 1) ? $clog2(PRIME_CYCLES) : 1;
  localparam logic [PRIME_CNT_WIDTH-1:0] PRIME_LAST = PRIME_CNT_WIDTH'(PRIME_CYCLES - 1);
  localparam logic [PIX_CNT_WIDTH-1:0]   PIX_LAST   = PIX_CNT_WIDTH'(PIXELS_PER_FRAME - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RESET  = 3'd1,
    S_PRIME  = 3'd2,
    S_ACTIVE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t                     state_q, state_d;
  logic                       front_bank_q, front_bank_d;
  logic                       commit_pending_q, commit_pending_d;
  logic [PIX_CNT_WIDTH-1:0]   pixel_cnt_q, pixel_cnt_d;
  logic [PRIME_CNT_WIDTH-1:0] prime_cnt_q, prime_cnt_d;
  logic [15:0]                frame_count_q, frame_count_d;
  logic                       pixel_underrun_q, pixel_underrun_d;
  logic                       frame_overrun_q, frame_overrun_d;

  logic commit_now;
  logic start_accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      front_bank_q     <= 1'b0;
      commit_pending_q <= 1'b0;
      pixel_cnt_q      <= '0;
      prime_cnt_q      <= '0;
      frame_count_q    <= '0;
      pixel_underrun_q <= 1'b0;
      frame_overrun_q  <= 1'b0;
    end else begin
      state_q          <= state_d;
      front_bank_q     <= front_bank_d;
      commit_pending_q <= commit_pending_d;
      pixel_cnt_q      <= pixel_cnt_d;
      prime_cnt_q      <= prime_cnt_d;
      frame_count_q    <= frame_count_d;
      pixel_underrun_q <= pixel_underrun_d;
      frame_overrun_q  <= frame_overrun_d;
    end
  end

  // A same-cycle host_commit counts as already pending for the accepting frame_start.
  assign commit_now   = commit_pending_q | host_commit;
  assign start_accept = frame_start & ((state_q != S_IDLE) | commit_now);

  always_comb begin
    state_d          = state_q;
    front_bank_d     = front_bank_q;
    commit_pending_d = commit_now;
    pixel_cnt_d      = pixel_cnt_q;
    prime_cnt_d      = prime_cnt_q;
    frame_count_d    = frame_count_q;
    pixel_underrun_d = pixel_underrun_q;
    frame_overrun_d  = frame_overrun_q;

    if (pixel_valid && ((state_q == S_RESET) || (state_q == S_PRIME))) begin
      pixel_underrun_d = 1'b1;
    end

    if (start_accept) begin
      // frame_start beats everything, including the frame's final pixel.
      state_d     = S_RESET;
      pixel_cnt_d = '0;
      prime_cnt_d = '0;
      if (commit_now) begin
        front_bank_d     = ~front_bank_q;
        commit_pending_d = 1'b0;
      end
      if (state_q == S_ACTIVE) begin
        frame_overrun_d = 1'b1;
      end
    end else begin
      case (state_q)
        S_RESET: begin
          state_d     = S_PRIME;
          prime_cnt_d = '0;
        end
        S_PRIME: begin
          if (prime_cnt_q == PRIME_LAST) begin
            state_d = S_ACTIVE;
          end else begin
            prime_cnt_d = prime_cnt_q + PRIME_CNT_WIDTH'(1);
          end
        end
        S_ACTIVE: begin
          if (pixel_valid) begin
            if (pixel_cnt_q == PIX_LAST) begin
              state_d       = S_DONE;
              pixel_cnt_d   = '0;
              frame_count_d = frame_count_q + 16'd1;
            end else begin
              pixel_cnt_d = pixel_cnt_q + PIX_CNT_WIDTH'(1);
            end
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  assign dec_pixel_reset     = (state_q == S_IDLE) || (state_q == S_RESET);
  assign dec_pixel_read_next = pixel_valid && (state_q == S_ACTIVE);
  assign pixel_blank         = pixel_valid && (state_q != S_ACTIVE);
  assign ram_address         = {front_bank_q, dec_RAM_address};
  assign host_bank           = ~front_bank_q;
  assign frame_count         = frame_count_q;
  assign pixel_underrun      = pixel_underrun_q;
  assign frame_overrun       = frame_overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_huffman_frame_scheduler.sv
`default_nettype none
// Testbench for huffman_frame_scheduler: directed scenarios plus random traffic
// checked every cycle against a frame-phase reference model.
module tb_huffman_frame_scheduler;

  localparam int AW  = 16;
  localparam int N   = 8;
  localparam int PCW = 4;
  localparam int PC  = 2;
  localparam int OW  = 3 + (AW + 1) + 1 + 2 + 16;

  localparam int P_IDLE   = 0;
  localparam int P_RESET  = 1;
  localparam int P_PRIME  = 2;
  localparam int P_ACTIVE = 3;
  localparam int P_DONE   = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          frame_start;
  logic          pixel_valid;
  logic          host_commit;
  logic [AW-1:0] dec_RAM_address;
  logic          dec_pixel_reset;
  logic          dec_pixel_read_next;
  logic [AW:0]   ram_address;
  logic          host_bank;
  logic          pixel_blank;
  logic [15:0]   frame_count;
  logic          pixel_underrun;
  logic          frame_overrun;

  huffman_frame_scheduler #(
    .ADDR_WIDTH      (AW),
    .PIXELS_PER_FRAME(N),
    .PIX_CNT_WIDTH   (PCW),
    .PRIME_CYCLES    (PC)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .frame_start        (frame_start),
    .pixel_valid        (pixel_valid),
    .host_commit        (host_commit),
    .dec_RAM_address    (dec_RAM_address),
    .dec_pixel_reset    (dec_pixel_reset),
    .dec_pixel_read_next(dec_pixel_read_next),
    .ram_address        (ram_address),
    .host_bank          (host_bank),
    .pixel_blank        (pixel_blank),
    .frame_count        (frame_count),
    .pixel_underrun     (pixel_underrun),
    .frame_overrun      (frame_overrun)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc_n  = 0;

  // Reference model: the frame is described by whether decoding ever began,
  // how many cycles have passed since the accepting frame_start, and pixels served.
  bit          m_started, m_front, m_pending, m_und, m_ovr;
  int          m_ticks, m_served;
  logic [15:0] m_fc;

  logic [OW-1:0] obs_v, exp_v;
  logic          s_rn, s_rst, s_blank, s_msb, s_host, s_und, s_ovr;
  logic [15:0]   s_fc;
  bit   [2:0]    stim[$];

  function automatic int m_phase();
    if (!m_started)       return P_IDLE;
    if (m_ticks == 0)     return P_RESET;
    if (m_ticks <= PC)    return P_PRIME;
    if (m_served < N)     return P_ACTIVE;
    return P_DONE;
  endfunction

  task automatic model_reset();
    m_started = 0; m_front = 0; m_pending = 0; m_und = 0; m_ovr = 0;
    m_ticks = 0; m_served = 0; m_fc = '0;
  endtask

  task automatic model_step(input bit fs, input bit pv, input bit hc);
    int ph;
    bit commit;
    ph     = m_phase();
    commit = m_pending | hc;
    if (pv && (ph == P_RESET || ph == P_PRIME)) m_und = 1;
    if (fs && (m_started || commit)) begin
      if (ph == P_ACTIVE) m_ovr = 1;
      if (commit) begin
        m_front   = ~m_front;
        m_pending = 0;
      end
      m_started = 1;
      m_ticks   = 0;
      m_served  = 0;
    end else begin
      m_pending = commit;
      if (m_started) m_ticks++;
      if (pv && ph == P_ACTIVE) begin
        m_served++;
        if (m_served == N) m_fc++;
      end
    end
  endtask

  task automatic sample();
    int ph;
    ph    = m_phase();
    obs_v = {dec_pixel_read_next, dec_pixel_reset, pixel_blank, ram_address,
             host_bank, pixel_underrun, frame_overrun, frame_count};
    exp_v = {pixel_valid && ph == P_ACTIVE, ph == P_IDLE || ph == P_RESET,
             pixel_valid && ph != P_ACTIVE, m_front, dec_RAM_address, ~m_front,
             m_und, m_ovr, m_fc};
    s_rn = dec_pixel_read_next; s_rst = dec_pixel_reset; s_blank = pixel_blank;
    s_msb = ram_address[AW]; s_host = host_bank; s_und = pixel_underrun;
    s_ovr = frame_overrun; s_fc = frame_count;
  endtask

  task automatic cyc(input bit fs, input bit pv, input bit hc);
    @(negedge clk);
    frame_start     = fs;
    pixel_valid     = pv;
    host_commit     = hc;
    dec_RAM_address = AW'($urandom);
    #1;
    sample();
    @(posedge clk);
    model_step(fs, pv, hc);
    cyc_n++;
  endtask

  task automatic add(input bit fs, input bit pv, input bit hc, input int n);
    for (int i = 0; i < n; i++) stim.push_back({fs, pv, hc});
  endtask

  task automatic do_reset();
    @(negedge clk);
    frame_start = 0; pixel_valid = 0; host_commit = 0;
    rst_n = 0;
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0; frame_start = 0; pixel_valid = 0; host_commit = 0;
    dec_RAM_address = 16'h1234;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    sample();
    checks++;
    if (obs_v !== exp_v) begin
      errors++;
      $display("FAIL reset_values got=%h expected=%h", obs_v, exp_v);
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_first_frame();
    int rn_cnt = 0, rst_cnt = 0;
    cyc(0, 0, 1);
    cyc(1, 0, 0);
    stim.delete(); add(0, 0, 0, 4); add(0, 1, 0, N); add(0, 0, 0, 1);
    foreach (stim[i]) begin
      cyc(stim[i][2], stim[i][1], stim[i][0]);
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL first_frame cyc=%0d got=%h expected=%h", cyc_n, obs_v, exp_v);
      end
      rn_cnt  += int'(s_rn);
      rst_cnt += int'(s_rst);
    end
    checks++;
    if (rn_cnt != N) begin errors++; $display("FAIL first_frame_read_next got=%0d expected=%0d", rn_cnt, N); end
    checks++;
    if (rst_cnt != 1) begin errors++; $display("FAIL first_frame_reset_len got=%0d expected=1", rst_cnt); end
    checks++;
    if (s_fc !== 16'd1 || s_msb !== 1'b1 || s_host !== 1'b0) begin
      errors++;
      $display("FAIL first_frame_end got fc=%0d msb=%b host=%b expected fc=1 msb=1 host=0", s_fc, s_msb, s_host);
    end
  endtask

  task automatic test_same_bank();
    stim.delete(); add(1, 0, 0, 1); add(0, 0, 0, 4); add(0, 1, 0, N); add(0, 0, 0, 1);
    foreach (stim[i]) begin
      cyc(stim[i][2], stim[i][1], stim[i][0]);
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL same_bank cyc=%0d got=%h expected=%h", cyc_n, obs_v, exp_v);
      end
    end
    checks++;
    if (s_fc !== 16'd2 || s_msb !== 1'b1) begin
      errors++;
      $display("FAIL same_bank_end got fc=%0d msb=%b expected fc=2 msb=1", s_fc, s_msb);
    end
    stim.delete(); add(0, 0, 1, 1); add(1, 0, 0, 1); add(0, 0, 0, 4); add(0, 1, 0, N);
    foreach (stim[i]) begin
      cyc(stim[i][2], stim[i][1], stim[i][0]);
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL commit_toggle cyc=%0d got=%h expected=%h", cyc_n, obs_v, exp_v);
      end
    end
    checks++;
    if (s_msb !== 1'b0 || s_host !== 1'b1) begin
      errors++;
      $display("FAIL commit_toggle_bank got msb=%b host=%b expected msb=0 host=1", s_msb, s_host);
    end
  endtask

  task automatic test_underrun();
    cyc(1, 0, 0);
    cyc(0, 1, 0);
    checks++;
    if (s_blank !== 1'b1 || s_rn !== 1'b0) begin
      errors++;
      $display("FAIL underrun_blank got blank=%b rn=%b expected blank=1 rn=0", s_blank, s_rn);
    end
    stim.delete(); add(0, 0, 0, 3); add(0, 1, 0, N);
    foreach (stim[i]) begin
      cyc(stim[i][2], stim[i][1], stim[i][0]);
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL underrun cyc=%0d got=%h expected=%h", cyc_n, obs_v, exp_v);
      end
    end
    checks++;
    if (s_und !== 1'b1) begin errors++; $display("FAIL underrun_flag got=%b expected=1", s_und); end
  endtask

  task automatic test_overrun();
    logic [15:0] fc0;
    stim.delete(); add(1, 0, 0, 1); add(0, 0, 0, 4); add(0, 1, 0, 5); add(1, 0, 0, 1);
    foreach (stim[i]) cyc(stim[i][2], stim[i][1], stim[i][0]);
    fc0 = s_fc;
    cyc(0, 0, 0);
    checks++;
    if (s_ovr !== 1'b1 || s_rst !== 1'b1 || s_fc !== fc0) begin
      errors++;
      $display("FAIL overrun got ovr=%b rst=%b fc=%0d expected ovr=1 rst=1 fc=%0d", s_ovr, s_rst, s_fc, fc0);
    end
    stim.delete(); add(0, 0, 0, 3); add(0, 1, 0, N); add(0, 0, 0, 1);
    foreach (stim[i]) begin
      cyc(stim[i][2], stim[i][1], stim[i][0]);
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL overrun_restart cyc=%0d got=%h expected=%h", cyc_n, obs_v, exp_v);
      end
    end
    checks++;
    if (s_fc !== fc0 + 16'd1) begin errors++; $display("FAIL overrun_count got=%0d expected=%0d", s_fc, fc0 + 16'd1); end
  endtask

  task automatic test_commit_with_start();
    do_reset();
    cyc(1, 0, 1);
    cyc(0, 0, 0);
    checks++;
    if (s_msb !== 1'b1 || s_rst !== 1'b1) begin
      errors++;
      $display("FAIL commit_same_cycle got msb=%b rst=%b expected msb=1 rst=1", s_msb, s_rst);
    end
    stim.delete(); add(0, 0, 0, 3); add(0, 1, 0, 3); add(0, 0, 1, 1); add(0, 1, 0, 3);
    add(0, 0, 1, 1); add(0, 1, 0, 2); add(1, 0, 0, 1); add(0, 0, 0, 4); add(0, 1, 0, N);
    add(1, 0, 0, 1); add(0, 0, 0, 1);
    foreach (stim[i]) begin
      cyc(stim[i][2], stim[i][1], stim[i][0]);
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL double_commit cyc=%0d got=%h expected=%h", cyc_n, obs_v, exp_v);
      end
    end
    checks++;
    if (s_msb !== 1'b0) begin errors++; $display("FAIL double_commit_bank got=%b expected=0", s_msb); end
  endtask

  task automatic test_final_collision();
    logic [15:0] fc0;
    stim.delete(); add(0, 0, 0, 3); add(0, 1, 0, N); add(1, 0, 0, 1); add(0, 0, 0, 4); add(0, 1, 0, N - 1);
    foreach (stim[i]) cyc(stim[i][2], stim[i][1], stim[i][0]);
    fc0 = s_fc;
    cyc(1, 1, 0);
    checks++;
    if (s_rn !== 1'b1) begin errors++; $display("FAIL collision_read_next got=%b expected=1", s_rn); end
    cyc(0, 0, 0);
    checks++;
    if (s_fc !== fc0 || s_ovr !== 1'b1 || s_rst !== 1'b1) begin
      errors++;
      $display("FAIL collision got fc=%0d ovr=%b rst=%b expected fc=%0d ovr=1 rst=1", s_fc, s_ovr, s_rst, fc0);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    stim.delete(); add(0, 0, 1, 1); add(1, 0, 0, 1); add(0, 0, 0, 4); add(0, 1, 0, 3);
    foreach (stim[i]) cyc(stim[i][2], stim[i][1], stim[i][0]);
    @(negedge clk);
    pixel_valid = 0; frame_start = 0; host_commit = 0;
    #2 rst_n = 0;
    model_reset();
    #1;
    sample();
    checks++;
    if (obs_v !== exp_v) begin
      errors++;
      $display("FAIL async_reset got=%h expected=%h", obs_v, exp_v);
    end
    @(negedge clk);
    rst_n = 1;
    stim.delete(); add(1, 0, 0, 1); add(0, 1, 0, 5);
    foreach (stim[i]) begin
      cyc(stim[i][2], stim[i][1], stim[i][0]);
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL no_commit_idle cyc=%0d got=%h expected=%h", cyc_n, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      cyc($urandom_range(0, 29) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 24) == 0);
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL random cyc=%0d got=%h expected=%h", cyc_n, obs_v, exp_v);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cyc=%0d", cyc_n);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_first_frame();
    test_same_bank();
    test_underrun();
    test_overrun();
    test_commit_with_start();
    test_final_collision();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/huffman_frame_scheduler.md
# huffman_frame_scheduler

Frame-level controller for the Huffman chunk decoder in the video scanout path. It sequences the decoder's reset, priming and per-pixel advance against display timing. It also double-buffers the compressed-image RAM: the host fills the back bank while the decoder reads the front bank, and the banks swap only at a frame boundary after the host commits.

## Interface
- ADDR_WIDTH, 16: decoder word-address width; the RAM address is ADDR_WIDTH+1 bits (MSB = bank).
- PIXELS_PER_FRAME, 307200: pixels per frame; must be ≥ 2.
- PIX_CNT_WIDTH, 20: pixel counter width; must satisfy 2^PIX_CNT_WIDTH > PIXELS_PER_FRAME.
- PRIME_CYCLES, 2: idle cycles after decoder reset before the first advance; must be ≥ 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- frame_start  in  1  one-cycle pulse from display timing, at least PRIME_CYCLES+1 cycles before the frame's first pixel_valid.
- pixel_valid  in  1  display consumes one pixel this cycle.
- host_commit  in  1  one-cycle pulse: back bank holds a complete compressed frame.
- dec_RAM_address  in  ADDR_WIDTH  word address driven by the decoder.
- dec_pixel_reset  out  1  to decoder pixel_reset.
- dec_pixel_read_next  out  1  to decoder pixel_read_next.
- ram_address  out  ADDR_WIDTH+1  {front_bank, dec_RAM_address}, combinational.
- host_bank  out  1  bank the host may write; always ~front_bank.
- pixel_blank  out  1  pixel_valid is not served by the decoder; the display outputs black.
- frame_count  out  16  frames fully decoded; wraps.
- pixel_underrun  out  1  sticky error flag.
- frame_overrun  out  1  sticky error flag.

## Operation
- States: IDLE, RESET, PRIME, ACTIVE, DONE.
- IDLE: waits until a frame has been committed. Moves to RESET on frame_start if commit_pending is 1 (this includes a host_commit in the same cycle).
- RESET: lasts 1 cycle, then PRIME.
- PRIME: counts PRIME_CYCLES cycles, then ACTIVE.
- ACTIVE: on each pixel_valid, pixel_cnt increments. When a pixel_valid arrives with pixel_cnt == PIXELS_PER_FRAME-1: move to DONE, clear pixel_cnt, increment frame_count.
- DONE: on frame_start, move to RESET.
- Frame start in any non-IDLE state restarts the sequence:
  - frame_start in RESET, PRIME or ACTIVE moves to RESET and clears pixel_cnt.
  - If this happens in ACTIVE, frame_overrun is set.
- Bank swap:
  - commit_pending is set by host_commit and is sticky; repeated commits merge into one.
  - On any frame_start that causes entry to RESET: if commit_pending (or host_commit in the same cycle), toggle front_bank and clear commit_pending. Otherwise re-decode the same bank.
- Output decode:
  - dec_pixel_reset = 1 in IDLE and RESET. It is decoded from the state register only.
  - dec_pixel_read_next = pixel_valid AND state == ACTIVE, combinational.
  - pixel_blank = pixel_valid AND state != ACTIVE.
- pixel_valid in RESET or PRIME sets pixel_underrun. pixel_valid in IDLE or DONE is blanked without an error.
- Error flags clear only on rst_n.

## Timing
- Asynchronous reset values: state IDLE, front_bank 0, commit_pending 0, pixel_cnt 0, frame_count 0, both error flags 0.
- Outputs during reset: dec_pixel_reset 1, dec_pixel_read_next 0, host_bank 1.
- The decoder sees pixel_reset high for ≥ 1 cycle per frame. With PRIME_CYCLES=2, the first dec_pixel_read_next can occur 3 cycles after the frame_start edge.
- The bank bit changes in the cycle after the accepting frame_start, while dec_pixel_reset is high. The decoder's first RAM read then targets the new bank.
- Simultaneous events:
  - host_commit together with frame_start in IDLE or DONE: the swap applies to this frame.
  - host_commit together with frame_start in a state where the sequence restarts: the swap also applies.
  - frame_start together with the final pixel_valid in ACTIVE: frame_start wins. The result is RESET with frame_overrun set and frame_count not incremented.
- rst_n asserted mid-frame returns the block to IDLE immediately. The host must commit again before decoding resumes.

## Test plan
- Reset, host_commit, then frame_start, then 4 idle cycles, then PIXELS_PER_FRAME=8 pixel_valid pulses. Expected:
  - ram_address MSB = 1 and host_bank = 0.
  - dec_pixel_reset high for exactly 1 cycle after IDLE exit.
  - 8 dec_pixel_read_next pulses, then frame_count = 1 and state DONE.
- Second frame_start without a new commit: no bank toggle and frame_count = 2 after 8 pixels. Then commit followed by frame_start: front bank toggles back to 0.
- pixel_valid in the cycle right after frame_start: pixel_blank = 1, pixel_underrun = 1, no read_next pulse.
- frame_start after 5 of 8 pixels: frame_overrun = 1, dec_pixel_reset reasserts, pixel_cnt restarts, frame_count unchanged.
- host_commit and frame_start in the same cycle from IDLE: decoding starts on bank 1. Two commits inside one frame produce a single toggle.
- rst_n pulsed low mid-ACTIVE: all outputs return to reset values asynchronously, and a frame_start without a commit stays in IDLE.
